// File: rtl/core_pkg.sv
// Shared core types for the branch-prediction interface and predictor table.
// Entry and update widths are fixed here; the predictor parameters must match them.
package core;

  localparam int BP_PC_WIDTH    = 32;
  localparam int BP_TABLE_DEPTH = 256;
  localparam int BP_IW          = $clog2(BP_TABLE_DEPTH);
  localparam int BP_TAG_WIDTH   = 8;

  typedef struct packed {
    logic [BP_PC_WIDTH-1:0] base_pc;
    logic [BP_PC_WIDTH-1:0] targ_pc;
    logic                   valid;
  } branch_pred_req_t;

  typedef struct packed {
    logic pred_taken;
    logic exec_alt;
  } branch_pred_rsp_t;

  typedef struct packed {
    logic [BP_PC_WIDTH-1:0] base_pc;
    logic [BP_PC_WIDTH-1:0] targ_pc;
    logic                   taken;
    logic                   valid;
  } branch_pred_fb_t;

  localparam branch_pred_req_t branch_pred_req_rst = '0;
  localparam branch_pred_rsp_t branch_pred_rsp_rst = '0;
  localparam branch_pred_fb_t  branch_pred_fb_rst  = '0;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } bp_ctr_t;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_WIDTH-1:0] tag;
    bp_ctr_t                 ctr;
  } bp_entry_t;

  typedef struct packed {
    logic                    valid;
    logic [BP_IW-1:0]        idx;
    logic [BP_TAG_WIDTH-1:0] tag;
    bp_ctr_t                 ctr;
  } bp_upd_t;

  function automatic bp_ctr_t ctr_next(bp_ctr_t c, logic taken);
    if (taken) return (c == CTR_ST)  ? CTR_ST  : bp_ctr_t'(2'(c) + 2'd1);
    else       return (c == CTR_SNT) ? CTR_SNT : bp_ctr_t'(2'(c) - 2'd1);
  endfunction

  // A pending update overrides the stored entry at the same index.
  function automatic bp_entry_t bp_bypass(bp_upd_t upd, logic [BP_IW-1:0] idx, bp_entry_t tbl);
    if (upd.valid && upd.idx == idx) return '{valid: 1'b1, tag: upd.tag, ctr: upd.ctr};
    return tbl;
  endfunction

endpackage

// File: rtl/branch_pred_table.sv
// Predictor storage: one write port, rd_ports asynchronous read ports.
// Only the per-entry valid bits are reset.
module branch_pred_table
  import core::*;
#(
  parameter int depth    = BP_TABLE_DEPTH,
  parameter int rd_ports = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [BP_IW-1:0] waddr,
  input  bp_entry_t        wdata,
  input  logic [BP_IW-1:0] raddr [rd_ports],
  output bp_entry_t        rdata [rd_ports]
);

  logic [depth-1:0] valid_q;
  bp_entry_t        mem_q [depth];

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     valid_q <= '0;
    else if (we) valid_q[waddr] <= wdata.valid;
  end

  // NOTE: the array itself has no reset; tag/ctr are ignored while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    for (int r = 0; r < rd_ports; r++) begin
      rdata[r]       = mem_q[raddr[r]];
      rdata[r].valid = valid_q[raddr[r]];
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged 2-bit-counter branch predictor with s_pipe_cnt lookup ports and one update port.
// Optional global history indexing: define BRANCH_PRED_GHR_EN.
module branch_predictor
  import core::*;
#(
  parameter int s_pipe_cnt  = 3,
  parameter int table_depth = BP_TABLE_DEPTH,
  parameter int tag_width   = BP_TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  branch_pred_req_t branch_pred_req [s_pipe_cnt],
  input  branch_pred_fb_t  branch_pred_fb,
  output branch_pred_rsp_t branch_pred_rsp [s_pipe_cnt]
);

  localparam int iw    = $clog2(table_depth);
  localparam int n_rd  = s_pipe_cnt + 1;
  localparam int tag_lo = iw + 2;
  localparam int tag_hi = iw + tag_width + 1;

  logic [iw-1:0]        idx_mask;
  logic [iw-1:0]        lk_idx [n_rd];
  logic [tag_width-1:0] lk_tag [n_rd];
  bp_entry_t            rdata  [n_rd];
  bp_upd_t              upd_q, upd_d;
  bp_entry_t            fb_ent;
  logic                 unused_pc;

`ifdef BRANCH_PRED_GHR_EN
  logic [iw-1:0] ghr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               ghr <= '0;
    else if (en && branch_pred_fb.valid)   ghr <= {ghr[iw-2:0], branch_pred_fb.taken};
  end

  assign idx_mask = ghr;
`else
  assign idx_mask = '0;
`endif

  // Last read port belongs to the feedback path.
  always_comb begin
    unused_pc = ^{branch_pred_fb.targ_pc, branch_pred_fb.base_pc[BP_PC_WIDTH-1:tag_hi+1],
                  branch_pred_fb.base_pc[1:0]};
    for (int p = 0; p < s_pipe_cnt; p++) begin
      lk_idx[p] = branch_pred_req[p].base_pc[iw+1:2] ^ idx_mask;
      lk_tag[p] = branch_pred_req[p].base_pc[tag_hi:tag_lo];
      unused_pc = unused_pc ^ (^{branch_pred_req[p].base_pc[BP_PC_WIDTH-1:tag_hi+1],
                                 branch_pred_req[p].base_pc[1:0]});
    end
    lk_idx[s_pipe_cnt] = branch_pred_fb.base_pc[iw+1:2] ^ idx_mask;
    lk_tag[s_pipe_cnt] = branch_pred_fb.base_pc[tag_hi:tag_lo];
  end

  branch_pred_table #(
    .depth   (table_depth),
    .rd_ports(n_rd)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (en && upd_q.valid),
    .waddr(upd_q.idx),
    .wdata('{valid: 1'b1, tag: upd_q.tag, ctr: upd_q.ctr}),
    .raddr(lk_idx),
    .rdata(rdata)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bp_entry_t ent;
    ent = '0;
    for (int p = 0; p < s_pipe_cnt; p++) begin
      branch_pred_rsp[p] = branch_pred_rsp_rst;
      ent = bp_bypass(upd_q, lk_idx[p], rdata[p]);
      if (branch_pred_req[p].valid) begin
        if (ent.valid && ent.tag == lk_tag[p]) begin
          branch_pred_rsp[p].pred_taken = ent.ctr[1];
          branch_pred_rsp[p].exec_alt   = (ent.ctr == CTR_WNT) || (ent.ctr == CTR_WT);
        end else begin
          branch_pred_rsp[p].pred_taken = branch_pred_req[p].targ_pc < branch_pred_req[p].base_pc;
          branch_pred_rsp[p].exec_alt   = 1'b1;
        end
      end
    end
  end

  // Feedback read-modify: saturate on a hit, reallocate on a miss.
  always_comb begin
    fb_ent      = bp_bypass(upd_q, lk_idx[s_pipe_cnt], rdata[s_pipe_cnt]);
    upd_d       = '0;
    upd_d.valid = 1'b1;
    upd_d.idx   = lk_idx[s_pipe_cnt];
    upd_d.tag   = lk_tag[s_pipe_cnt];
    if (fb_ent.valid && fb_ent.tag == lk_tag[s_pipe_cnt])
      upd_d.ctr = ctr_next(fb_ent.ctr, branch_pred_fb.taken);
    else
      upd_d.ctr = branch_pred_fb.taken ? CTR_WT : CTR_WNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q <= '0;
    end else if (en) begin
      if (branch_pred_fb.valid) upd_q       <= upd_d;
      else                      upd_q.valid <= 1'b0;
    end
  end

endmodule
